// File: rtl/accel_cmd_sched.sv
// Round-robin scheduler sharing one register-mapped add accelerator between
// NUM_REQ requesters: write A, write B, start, wait irq, read, clear, respond.
module accel_cmd_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_data,
  output logic                   resp_timeout,
  output logic                   busy,
  output logic                   acc_wr_en,
  output logic [3:0]             acc_addr,
  output logic [31:0]            acc_wr_data,
  input  logic [31:0]            acc_rd_data,
  input  logic                   acc_irq
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_A, S_WR_B, S_START, S_WAIT, S_CLEAR, S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            resp_valid_q, resp_valid_d;
  logic [ID_W-1:0] resp_id_q, resp_id_d;
  logic [31:0]     resp_data_q, resp_data_d;
  logic            resp_timeout_q, resp_timeout_d;
  logic            busy_q, busy_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [31:0]     gnt_a, gnt_b;

  // Two passes give the circular search starting at rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    gnt_a     = '0;
    gnt_b     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && req_valid[j] && (j >= int'(rr_ptr_q))) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (!gnt_found && req_valid[j] && (j < int'(rr_ptr_q))) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(j);
      end
    end
    for (int j = 0; j < NUM_REQ; j++) begin
      if (ID_W'(j) == gnt_id) begin
        gnt_a = req_a[j*32 +: 32];
        gnt_b = req_b[j*32 +: 32];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    a_d            = a_q;
    b_d            = b_q;
    id_d           = id_q;
    resp_valid_d   = resp_valid_q;
    resp_id_d      = resp_id_q;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;
    req_ready      = '0;
    acc_wr_en      = 1'b0;
    acc_addr       = 4'd0;
    acc_wr_data    = 32'd0;

    case (state_q)
      S_IDLE: begin
        if (gnt_found && !rst) begin
          for (int j = 0; j < NUM_REQ; j++) begin
            req_ready[j] = (ID_W'(j) == gnt_id);
          end
          a_d      = gnt_a;
          b_d      = gnt_b;
          id_d     = gnt_id;
          rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + 1'b1;
          state_d  = S_WR_A;
        end
      end
      S_WR_A: begin
        acc_wr_en   = 1'b1;
        acc_addr    = 4'd2;
        acc_wr_data = a_q;
        state_d     = S_WR_B;
      end
      S_WR_B: begin
        acc_wr_en   = 1'b1;
        acc_addr    = 4'd3;
        acc_wr_data = b_q;
        state_d     = S_START;
      end
      S_START: begin
        acc_wr_en   = 1'b1;
        acc_addr    = 4'd0;
        acc_wr_data = 32'h1;
        cnt_d       = 8'd0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        acc_addr = 4'd1;
        if (acc_irq) begin
          resp_data_d    = acc_rd_data;
          resp_timeout_d = 1'b0;
          resp_id_d      = id_q;
          state_d        = S_CLEAR;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          resp_data_d    = 32'd0;
          resp_timeout_d = 1'b1;
          resp_id_d      = id_q;
          state_d        = S_CLEAR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      // The done clear also drops an irq that arrives after a timeout.
      S_CLEAR: begin
        acc_wr_en    = 1'b1;
        acc_addr     = 4'd0;
        acc_wr_data  = 32'h2;
        resp_valid_d = 1'b1;
        state_d      = S_RESP;
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= '0;
      cnt_q          <= 8'd0;
      a_q            <= 32'd0;
      b_q            <= 32'd0;
      id_q           <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_data_q    <= 32'd0;
      resp_timeout_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      a_q            <= a_d;
      b_q            <= b_d;
      id_q           <= id_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
      busy_q         <= busy_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_id      = resp_id_q;
  assign resp_data    = resp_data_q;
  assign resp_timeout = resp_timeout_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_accel_cmd_sched.sv
// Scoreboard bench for accel_cmd_sched with a small add-accelerator model.
module tb_accel_cmd_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 15;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*32-1:0] req_a = '0;
  logic [NUM_REQ*32-1:0] req_b = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  resp_valid;
  logic                  resp_ready = 1'b1;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic                  resp_timeout;
  logic                  busy;
  logic                  acc_wr_en;
  logic [3:0]            acc_addr;
  logic [31:0]           acc_wr_data;
  logic [31:0]           acc_rd_data;
  logic                  acc_irq;

  accel_cmd_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_timeout(resp_timeout),
    .busy(busy), .acc_wr_en(acc_wr_en), .acc_addr(acc_addr),
    .acc_wr_data(acc_wr_data), .acc_rd_data(acc_rd_data), .acc_irq(acc_irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Accelerator model: irq rises one cycle after the start write.
  logic        irq_en = 1'b1;
  logic [31:0] ra, rb;
  logic        irq;
  always @(posedge clk) begin
    if (rst) begin
      ra <= '0; rb <= '0; irq <= 1'b0;
    end else if (acc_wr_en) begin
      case (acc_addr)
        4'd2: ra <= acc_wr_data;
        4'd3: rb <= acc_wr_data;
        4'd0: begin
          if (acc_wr_data[1]) irq <= 1'b0;
          else if (acc_wr_data[0] && irq_en) irq <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign acc_irq     = irq;
  assign acc_rd_data = (acc_addr == 4'd1) ? ra + rb : 32'h0;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        to;
    int          lat;
    int          acc_cyc;
  } sb_t;
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  sb_t  sb[$];
  wr_t  wlog[$];
  int   glog[$];
  int   alog[$];
  logic [31:0] exp_data [NUM_REQ];
  logic        exp_to   [NUM_REQ];
  int          exp_lat  [NUM_REQ];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: logs writes and grants, pushes expected responses, checks responses.
  logic rv_prev = 1'b0;
  int   g;
  sb_t  e;
  always @(negedge clk) begin
    if (!rst) begin
      if (acc_wr_en) wlog.push_back('{acc_addr, acc_wr_data, cyc});
      if (req_ready != '0) begin
        chk("req_ready_onehot", 64'($onehot(req_ready)), 64'd1);
        g = 0;
        for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) g = k;
        glog.push_back(g);
        alog.push_back(cyc);
        sb.push_back('{g, exp_data[g], exp_to[g], exp_lat[g], cyc});
      end
      if (resp_valid && !rv_prev) begin
        if (sb.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
        else chk("resp_latency", 64'(cyc - sb[0].acc_cyc), 64'(sb[0].lat));
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_data", 64'(resp_data), 64'(e.data));
          chk("resp_timeout", 64'(resp_timeout), 64'(e.to));
        end
      end
    end
    rv_prev = resp_valid;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_accept(input int idx, output int c);
    bit done = 0;
    c = -1;
    for (int n = 0; n < 300 && !done; n++) begin
      @(negedge clk);
      if (req_ready[idx]) begin
        c = cyc;
        done = 1;
        @(posedge clk);
        #2;
        req_valid[idx] = 1'b0;
      end
    end
    if (!done) chk("accept_wait_expired", 64'd1, 64'd0);
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ed, input logic eto, input int lat);
    exp_data[idx] = ed;
    exp_to[idx]   = eto;
    exp_lat[idx]  = lat;
    req_a[idx*32 +: 32] = a;
    req_b[idx*32 +: 32] = b;
    req_valid[idx] = 1'b1;
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (!busy && !resp_valid && sb.size() == 0 && req_valid == '0) done = 1;
    end
    if (!done) chk("idle_wait_expired", 64'd1, 64'd0);
    tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, resp_valid, resp_id, resp_timeout, busy, acc_wr_en, acc_addr}), 64'd0);
    chk({tag, "_resp_data"}, 64'(resp_data), 64'd0);
    chk({tag, "_acc_wr_data"}, 64'(acc_wr_data), 64'd0);
  endtask

  task automatic chk_wlog(input string tag, input int c, input int clr_off,
                          input logic [31:0] a, input logic [31:0] b);
    chk({tag, "_nwrites"}, 64'(wlog.size()), 64'd4);
    if (wlog.size() == 4) begin
      chk({tag, "_wr0"}, {28'd0, wlog[0].addr, wlog[0].data}, {28'd0, 4'd2, a});
      chk({tag, "_wr1"}, {28'd0, wlog[1].addr, wlog[1].data}, {28'd0, 4'd3, b});
      chk({tag, "_wr2"}, {28'd0, wlog[2].addr, wlog[2].data}, {28'd0, 4'd0, 32'h1});
      chk({tag, "_wr3"}, {28'd0, wlog[3].addr, wlog[3].data}, {28'd0, 4'd0, 32'h2});
      chk({tag, "_wr_cycles"}, {16'(wlog[0].cyc - c), 16'(wlog[1].cyc - c), 16'(wlog[2].cyc - c), 16'(wlog[3].cyc - c)},
          {16'd1, 16'd2, 16'd3, 16'(clr_off)});
    end
  endtask

  initial begin
    int c, c0, c1, n0, r;
    for (int k = 0; k < NUM_REQ; k++) begin
      exp_data[k] = '0; exp_to[k] = 1'b0; exp_lat[k] = 6;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    tick();

    // Single request: requester 1, 5 + 7.
    wlog.delete();
    set_req(1, 32'd5, 32'd7, 32'd12, 1'b0, 6);
    wait_accept(1, c);
    wait_idle();
    chk_wlog("single", c, 5, 32'd5, 32'd7);

    // Wrap-around sum.
    set_req(2, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0, 6);
    wait_accept(2, c);
    wait_idle();

    // Round-robin from a fresh reset with every requester pending.
    rst = 1'b1; tick(); rst = 1'b0;
    n0 = glog.size();
    set_req(0, 32'd1, 32'd2, 32'd3, 1'b0, 6);
    set_req(1, 32'd100, 32'd23, 32'd123, 1'b0, 6);
    set_req(2, 32'h8000_0000, 32'h8000_0000, 32'd0, 1'b0, 6);
    set_req(3, 32'd7, 32'hFFFF_FFF0, 32'hFFFF_FFF7, 1'b0, 6);
    for (int n = 0; n < 200 && glog.size() < n0 + 5; n++) @(negedge clk);
    @(posedge clk);
    #2 req_valid = '0;
    wait_idle();
    chk("rr_count", 64'(glog.size() - n0), 64'd5);
    if (glog.size() >= n0 + 5) begin
      chk("rr_order", {16'(glog[n0]), 16'(glog[n0+1]), 16'(glog[n0+2]), 16'(glog[n0+3])},
          {16'd0, 16'd1, 16'd2, 16'd3});
      chk("rr_wrap", 64'(glog[n0+4]), 64'd0);
      for (int k = 1; k < 5; k++) chk("rr_spacing", 64'(alog[n0+k] - alog[n0+k-1]), 64'd7);
    end

    // Timeout: accelerator never raises irq.
    irq_en = 1'b0;
    wlog.delete();
    set_req(3, 32'd9, 32'd9, 32'd0, 1'b1, 20);
    wait_accept(3, c);
    wait_idle();
    chk_wlog("timeout", c, 19, 32'd9, 32'd9);
    irq_en = 1'b1;

    // Backpressure: hold resp_ready low for 20 cycles with requester 1 pending.
    resp_ready = 1'b0;
    set_req(0, 32'd40, 32'd2, 32'd42, 1'b0, 6);
    wait_accept(0, c0);
    set_req(1, 32'd3, 32'd4, 32'd7, 1'b0, 6);
    for (int n = 0; n < 50 && !resp_valid; n++) @(negedge clk);
    for (int n = 0; n < 20; n++) begin
      chk("bp_hold", {16'(resp_valid), 16'(resp_id), 16'(resp_timeout), 16'(req_ready)},
          {16'd1, 16'd0, 16'd0, 16'd0});
      chk("bp_data", 64'(resp_data), 64'd42);
      @(negedge clk);
    end
    tick();
    resp_ready = 1'b1;
    r = cyc;
    wait_accept(1, c1);
    chk("bp_accept_cycle", 64'(c1), 64'(r + 1));
    wait_idle();

    // Reset while waiting on the accelerator.
    irq_en = 1'b0;
    set_req(2, 32'd1, 32'd1, 32'd2, 1'b0, 6);
    wait_accept(2, c);
    for (int n = 0; n < 20 && acc_addr != 4'd1; n++) @(negedge clk);
    chk("mid_in_wait", 64'(acc_addr), 64'd1);
    tick();
    tick();
    rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_zero("midrst");
    tick();
    irq_en = 1'b1;
    n0 = glog.size();
    set_req(3, 32'd20, 32'd22, 32'd42, 1'b0, 6);
    set_req(0, 32'd11, 32'd22, 32'd33, 1'b0, 6);
    wait_accept(0, c0);
    wait_accept(3, c1);
    wait_idle();
    chk("midrst_first_grant", 64'(glog[n0]), 64'd0);
    chk("midrst_second_grant", 64'(glog[n0+1]), 64'd3);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
